multicycle_controller: RTL

//  Multi-cycle RV32 control FSM for the shared-memory core. One ALU and one

---
 rtl/multicycle_controller.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32 control FSM: sequences one shared ALU and one unified
// memory port through the steps of each instruction, with memory wait
// states and a per-access watchdog that aborts a stalled access.
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       retire,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
    MEMWRITE = 4'd5, EXECR = 4'd6, ALUWB = 4'd7, EXECI = 4'd8, JAL = 4'd9,
    BEQ = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  // Counter value at which the last permitted wait cycle is reached.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_r, next_s;
  logic [7:0] cnt_r;
  logic       in_mem_s, timeout_s;
  logic       mem_req_s, adr_src_s, mem_write_s, ir_write_s, pc_write_s;
  logic       reg_write_s, retire_s, illegal_s;
  logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s, alu_op_s, imm_src_s;

  // A watchdog timeout is only possible while a memory access is waiting.
  assign in_mem_s  = (state_r == FETCH) || (state_r == MEMREAD) || (state_r == MEMWRITE);
  assign timeout_s = (TIMEOUT_CYCLES != 0) && in_mem_s && !mem_ready && (cnt_r == TO_LAST);

  // State register; reset forces the FSM back to instruction fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Wait-cycle counter: counts stalled memory cycles, clears on any state
  // change or timeout, and saturates so a disabled watchdog never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 8'd0;
    end else if (in_mem_s && !mem_ready && !timeout_s && (next_s == state_r)) begin
      cnt_r <= (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;
    end else begin
      cnt_r <= 8'd0;
    end
  end

  // Next-state and per-state control decode; defaults keep unlisted controls low.
  always_comb begin
    next_s       = state_r;
    mem_req_s    = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    retire_s     = 1'b0;
    illegal_s    = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    case (state_r)
      FETCH: begin
        mem_req_s    = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        if (mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          next_s     = DECODE;
        end else begin
          next_s = FETCH;
        end
      end
      DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        case (op)
          OP_LW, OP_SW: next_s = MEMADR;
          OP_R:         next_s = EXECR;
          OP_I:         next_s = EXECI;
          OP_JAL:       next_s = JAL;
          OP_BEQ:       next_s = BEQ;
          default: begin
            illegal_s = 1'b1;
            next_s    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        if (op == OP_LW) begin
          next_s = MEMREAD;
        end else if (op == OP_SW) begin
          next_s = MEMWRITE;
        end else begin
          next_s = FETCH;
        end
      end
      MEMREAD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
        if (mem_ready) begin
          next_s = MEMWB;
        end else if (timeout_s) begin
          next_s = FETCH;
        end else begin
          next_s = MEMREAD;
        end
      end
      MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        next_s       = FETCH;
      end
      MEMWRITE: begin
        mem_req_s   = 1'b1;
        adr_src_s   = 1'b1;
        // An aborted store must not write in its final cycle.
        mem_write_s = !timeout_s;
        if (mem_ready) begin
          retire_s = 1'b1;
          next_s   = FETCH;
        end else if (timeout_s) begin
          next_s = FETCH;
        end else begin
          next_s = MEMWRITE;
        end
      end
      EXECR: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b10;
        next_s      = ALUWB;
      end
      EXECI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b10;
        next_s      = ALUWB;
      end
      ALUWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        next_s      = FETCH;
      end
      JAL: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_write_s  = 1'b1;
        next_s      = ALUWB;
      end
      BEQ: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b01;
        pc_write_s  = zero;
        retire_s    = 1'b1;
        next_s      = FETCH;
      end
      default: next_s = FETCH;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (op)
      OP_SW:   imm_src_s = 2'b01;
      OP_BEQ:  imm_src_s = 2'b10;
      OP_JAL:  imm_src_s = 2'b11;
      default: imm_src_s = 2'b00;
    endcase
  end

  // Output stage: while reset is held only the fetch request is visible, so
  // no input-dependent strobe can leak out during reset.
  always_comb begin
    state = state_r;
    if (!rst) begin
      mem_req   = 1'b1;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      ImmSrc    = 2'b00;
      retire    = 1'b0;
      illegal   = 1'b0;
      bus_err   = 1'b0;
    end else begin
      mem_req   = mem_req_s;
      AdrSrc    = adr_src_s;
      MemWrite  = mem_write_s;
      IRWrite   = ir_write_s;
      PCWrite   = pc_write_s;
      RegWrite  = reg_write_s;
      ResultSrc = result_src_s;
      ALUSrcA   = alu_src_a_s;
      ALUSrcB   = alu_src_b_s;
      ALUOp     = alu_op_s;
      ImmSrc    = imm_src_s;
      retire    = retire_s;
      illegal   = illegal_s;
      bus_err   = timeout_s;
    end
  end

endmodule
